ntt_core_writeback: RTL and testbench

// Write-back side of an NTT core: consumes the four butterfly results r1..r4 each beat and

---
 rtl/ntt_core_writeback_if.sv | 32 +++
 rtl/ntt_core_writeback.sv | 232 +++++++++++++++++++++++
 tb/tb_ntt_core_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_core_writeback_if.sv
// NTT write-back bus: read-issue tracking, butterfly results and
// the upper/lower core RAM write ports of the next stage.
interface ntt_core_writeback_if #(
    parameter int W      = 30,
    parameter int ADDR_W = 9
);
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [W-1:0]      r1;
    logic [W-1:0]      r2;
    logic [W-1:0]      r3;
    logic [W-1:0]      r4;

    logic              upper_write_enable;
    logic [ADDR_W-1:0] upper_write_address;
    logic [2*W-1:0]    upper_data_output;
    logic              lower_write_enable;
    logic [ADDR_W-1:0] lower_write_address;
    logic [2*W-1:0]    lower_data_output;

    modport master (
        output issue_valid, issue_addr, r1, r2, r3, r4,
        input  upper_write_enable, upper_write_address, upper_data_output,
        input  lower_write_enable, lower_write_address, lower_data_output
    );

    modport slave (
        input  issue_valid, issue_addr, r1, r2, r3, r4,
        output upper_write_enable, upper_write_address, upper_data_output,
        output lower_write_enable, lower_write_address, lower_data_output
    );
endinterface

// File: rtl/ntt_core_writeback.sv
// NTT write-back: pairs butterfly beats into 2*W-bit RAM words,
// tracks the issued beats through the pipe and flips the bank per stage.
module ntt_core_writeback #(
    parameter int W        = 30,
    parameter int ADDR_W   = 9,
    parameter int PIPE_LAT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W:0]        beats,
    ntt_core_writeback_if.slave    bus,
    output logic                   write_select,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   MAX_BEATS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] HALF      = {1'b1, {(ADDR_W-1){1'b0}}};

    // issue tracking delay line, aligned with r1..r4 at its tail
    logic [ADDR_W:0] dl_q [PIPE_LAT];
    logic [ADDR_W:0] dl_d [PIPE_LAT];
    logic            dv;
    logic [ADDR_W-1:0] daddr;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   beats_q, beats_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [W-1:0]      h1_q, h1_d, h2_q, h2_d, h3_q, h3_d, h4_q, h4_d;
    logic [ADDR_W-1:0] a_q, a_d;

    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [2*W-1:0]    pend_up_q, pend_up_d;
    logic [2*W-1:0]    pend_lo_q, pend_lo_d;

    logic              uwe_q, uwe_d, lwe_q, lwe_d;
    logic [ADDR_W-1:0] ua_q, ua_d, la_q, la_d;
    logic [2*W-1:0]    ud_q, ud_d, ld_q, ld_d;
    logic              ws_q, ws_d;
    logic              err_q, err_d;

    logic              legal;
    logic              cap;

    assign dv    = dl_q[PIPE_LAT-1][ADDR_W];
    assign daddr = dl_q[PIPE_LAT-1][ADDR_W-1:0];

    assign legal = (beats != '0) && !beats[0] && (beats <= MAX_BEATS);

    // shift the issue record one stage per cycle
    always_comb begin
        dl_d[0] = {bus.issue_valid, bus.issue_addr};
        for (int i = 1; i < PIPE_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    // delay line registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    // stage FSM, beat pairing and write port scheduling
    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        h3_d        = h3_q;
        h4_d        = h4_q;
        a_d         = a_q;
        pend_d      = 1'b0;
        pend_last_d = pend_last_q;
        pend_addr_d = pend_addr_q;
        pend_up_d   = pend_up_q;
        pend_lo_d   = pend_lo_q;
        last_wr_d   = 1'b0;
        uwe_d       = 1'b0;
        lwe_d       = 1'b0;
        ua_d        = ua_q;
        la_d        = la_q;
        ud_d        = ud_q;
        ld_d        = ld_q;
        ws_d        = ws_q;
        err_d       = 1'b0;
        cap         = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start) begin
                    if (legal) begin
                        state_d = S_RUN;
                        beats_d = beats;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (start) begin
                    err_d = 1'b1;
                end
                cap = dv && (cnt_q < beats_q);
                // last pending word went out last cycle
                if (last_wr_q) begin
                    state_d = S_DONE;
                    ws_d    = ~ws_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap) begin
            cnt_d = cnt_q + 1'b1;
            if (!cnt_q[0]) begin
                h1_d = bus.r1;
                h2_d = bus.r2;
                h3_d = bus.r3;
                h4_d = bus.r4;
                a_d  = daddr >> 1;
            end else begin
                uwe_d       = 1'b1;
                lwe_d       = 1'b1;
                ua_d        = a_q;
                la_d        = a_q;
                ud_d        = {bus.r1, h1_q};
                ld_d        = {bus.r2, h2_q};
                pend_d      = 1'b1;
                pend_last_d = (cnt_q == beats_q - 1'b1);
                pend_addr_d = a_q + HALF;
                pend_up_d   = {bus.r3, h3_q};
                pend_lo_d   = {bus.r4, h4_q};
            end
        end

        // second half of a pair lands one cycle after the primary
        if (pend_q) begin
            uwe_d     = 1'b1;
            lwe_d     = 1'b1;
            ua_d      = pend_addr_q;
            la_d      = pend_addr_q;
            ud_d      = pend_up_q;
            ld_d      = pend_lo_q;
            last_wr_d = pend_last_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beats_q     <= '0;
            cnt_q       <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            h4_q        <= '0;
            a_q         <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            last_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_up_q   <= '0;
            pend_lo_q   <= '0;
            uwe_q       <= 1'b0;
            lwe_q       <= 1'b0;
            ua_q        <= '0;
            la_q        <= '0;
            ud_q        <= '0;
            ld_q        <= '0;
            ws_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            h3_q        <= h3_d;
            h4_q        <= h4_d;
            a_q         <= a_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            last_wr_q   <= last_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_up_q   <= pend_up_d;
            pend_lo_q   <= pend_lo_d;
            uwe_q       <= uwe_d;
            lwe_q       <= lwe_d;
            ua_q        <= ua_d;
            la_q        <= la_d;
            ud_q        <= ud_d;
            ld_q        <= ld_d;
            ws_q        <= ws_d;
            err_q       <= err_d;
        end
    end

    assign bus.upper_write_enable  = uwe_q;
    assign bus.upper_write_address = ua_q;
    assign bus.upper_data_output   = ud_q;
    assign bus.lower_write_enable  = lwe_q;
    assign bus.lower_write_address = la_q;
    assign bus.lower_data_output   = ld_q;
    assign write_select            = ws_q;
    assign busy                    = (state_q == S_RUN);
    assign done                    = (state_q == S_DONE);
    assign error                   = err_q;
endmodule

// File: tb/tb_ntt_core_writeback.sv
// Scoreboard bench for ntt_core_writeback: directed stage runs,
// errors and mid-stage reset, checked by an independent write monitor.
module tb_ntt_core_writeback;
    localparam int W    = 30;
    localparam int AW   = 9;
    localparam int LAT  = 8;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [2*W-1:0] up;
        logic [2*W-1:0] lo;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [AW:0] beats = '0;
    logic write_select, busy, done, error;

    ntt_core_writeback_if #(.W(W), .ADDR_W(AW)) bus ();

    ntt_core_writeback #(.W(W), .ADDR_W(AW), .PIPE_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .beats        (beats),
        .bus          (bus.slave),
        .write_select (write_select),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int dup_cnt = 0;
    bit [511:0] seen;
    logic exp_ws = 1'b0;
    wr_t sb[$];

    logic [W-1:0] rdat [4][512];
    logic [AW:0]  hist [LAT] = '{default: '0};

    // result source: r1..r4 follow the issued address LAT cycles later
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= {bus.issue_valid, bus.issue_addr};
    end
    assign bus.r1 = rdat[0][hist[LAT-1][AW-1:0]];
    assign bus.r2 = rdat[1][hist[LAT-1][AW-1:0]];
    assign bus.r3 = rdat[2][hist[LAT-1][AW-1:0]];
    assign bus.r4 = rdat[3][hist[LAT-1][AW-1:0]];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // monitor: every write must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.upper_write_enable || bus.lower_write_enable) begin
                wr_t e;
                chk("upper_we", 64'(bus.upper_write_enable), 64'd1);
                chk("lower_we", 64'(bus.lower_write_enable), 64'd1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d",
                             bus.upper_write_address);
                end else begin
                    e = sb.pop_front();
                    chk("up_addr", 64'(bus.upper_write_address), 64'(e.addr));
                    chk("lo_addr", 64'(bus.lower_write_address), 64'(e.addr));
                    chk("up_data", 64'(bus.upper_data_output), 64'(e.up));
                    chk("lo_data", 64'(bus.lower_data_output), 64'(e.lo));
                end
                if (seen[bus.upper_write_address]) dup_cnt++;
                seen[bus.upper_write_address] = 1'b1;
                wr_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_gen();
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 512; a++)
                rdat[k][a] = {6'(k + 1), 8'(a * 5 + k), 7'd0, 9'(a)};
    endtask

    task automatic fill_t2();
        fill_gen();
        for (int k = 0; k < 4; k++) begin
            rdat[k][6] = W'(11 + k);
            rdat[k][7] = W'(21 + k);
        end
    endtask

    task automatic clr_stats();
        wr_cnt = 0;
        done_cnt = 0;
        dup_cnt = 0;
        seen = '0;
    endtask

    task automatic push_pair(input int ae, input int ao);
        logic [AW-1:0] a;
        a = AW'(ae >> 1);
        sb.push_back('{a, {rdat[0][ao], rdat[0][ae]},
                          {rdat[1][ao], rdat[1][ae]}});
        sb.push_back('{a + 9'd256, {rdat[2][ao], rdat[2][ae]},
                                   {rdat[3][ao], rdat[3][ae]}});
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            if (done) got = 1'b1;
        end
        chk(nm, 64'(got), 64'd1);
        if (got) begin
            exp_ws = ~exp_ws;
            chk("ws_toggle", 64'(write_select), 64'(exp_ws));
            step();
            chk("busy_after", 64'(busy), 64'd0);
            chk("done_pulse", 64'(done), 64'd0);
        end
    endtask

    task automatic run_pair();
        fill_t2();
        start = 1'b1;
        beats = 10'd2;
        bus.issue_valid = 1'b1;
        bus.issue_addr = 9'd6;
        step();
        start = 1'b0;
        bus.issue_addr = 9'd7;
        push_pair(6, 7);
        chk("t2_busy", 64'(busy), 64'd1);
        step();
        bus.issue_valid = 1'b0;
        repeat (7) step();
        chk("t2_we_c8", 64'(bus.upper_write_enable), 64'd0);
        step();
        chk("t2_we_c9", 64'(bus.upper_write_enable), 64'd1);
        chk("t2_ua_c9", 64'(bus.upper_write_address), 64'd3);
        chk("t2_ud_c9", 64'(bus.upper_data_output), {4'd0, 30'd21, 30'd11});
        chk("t2_ld_c9", 64'(bus.lower_data_output), {4'd0, 30'd22, 30'd12});
        step();
        chk("t2_we_c10", 64'(bus.lower_write_enable), 64'd1);
        chk("t2_la_c10", 64'(bus.lower_write_address), 64'd259);
        chk("t2_ud_c10", 64'(bus.upper_data_output), {4'd0, 30'd23, 30'd13});
        chk("t2_ld_c10", 64'(bus.lower_data_output), {4'd0, 30'd24, 30'd14});
        step();
        exp_ws = ~exp_ws;
        chk("t2_done_c11", 64'(done), 64'd1);
        chk("t2_ws_c11", 64'(write_select), 64'(exp_ws));
        chk("t2_we_c11", 64'(bus.upper_write_enable), 64'd0);
        step();
        chk("t2_done_c12", 64'(done), 64'd0);
        chk("t2_busy_c12", 64'(busy), 64'd0);
    endtask

    task automatic run_stream(input bit gapped, input string nm);
        fill_gen();
        clr_stats();
        for (int i = 0; i < 512; i++) begin
            if (gapped && i > 0 && $urandom_range(0, 1) == 1) begin
                bus.issue_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            bus.issue_valid = 1'b1;
            bus.issue_addr = AW'(i);
            if (i == 0) begin
                start = 1'b1;
                beats = 10'd512;
            end
            if (i[0]) push_pair(i - 1, i);
            step();
            start = 1'b0;
        end
        bus.issue_valid = 1'b0;
        wait_done(100, {nm, "_done"});
        chk({nm, "_wr_cnt"}, 64'(wr_cnt), 64'd512);
        chk({nm, "_all_addr"}, 64'($countones(seen)), 64'd512);
        chk({nm, "_dups"}, 64'(dup_cnt), 64'd0);
        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int bad [3] = '{3, 0, 514};
        bus.issue_valid = 1'b0;
        bus.issue_addr = '0;
        fill_gen();
        clr_stats();

        // reset
        repeat (3) step();
        chk("rst_uwe", 64'(bus.upper_write_enable), 64'd0);
        chk("rst_ua", 64'(bus.upper_write_address), 64'd0);
        chk("rst_ud", 64'(bus.upper_data_output), 64'd0);
        chk("rst_lwe", 64'(bus.lower_write_enable), 64'd0);
        chk("rst_la", 64'(bus.lower_write_address), 64'd0);
        chk("rst_ld", 64'(bus.lower_data_output), 64'd0);
        chk("rst_ws", 64'(write_select), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_uwe", 64'(bus.upper_write_enable), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ws", 64'(write_select), 64'd0);

        // single pair
        run_pair();
        repeat (3) step();

        // full and gapped streams
        run_stream(1'b0, "full");
        repeat (3) step();
        run_stream(1'b1, "gap");
        repeat (3) step();

        // illegal starts
        clr_stats();
        foreach (bad[i]) begin
            start = 1'b1;
            beats = 10'(bad[i]);
            step();
            start = 1'b0;
            chk("bad_err", 64'(error), 64'd1);
            chk("bad_busy", 64'(busy), 64'd0);
            step();
            chk("bad_err_clr", 64'(error), 64'd0);
        end
        repeat (12) step();
        chk("bad_no_wr", 64'(wr_cnt), 64'd0);

        // start while running
        fill_gen();
        start = 1'b1;
        beats = 10'd4;
        bus.issue_valid = 1'b1;
        bus.issue_addr = 9'd10;
        step();
        beats = 10'd2;
        bus.issue_addr = 9'd11;
        push_pair(10, 11);
        step();
        start = 1'b0;
        chk("run_err", 64'(error), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        bus.issue_addr = 9'd12;
        step();
        chk("run_err_clr", 64'(error), 64'd0);
        bus.issue_addr = 9'd13;
        push_pair(12, 13);
        step();
        bus.issue_valid = 1'b0;
        wait_done(30, "run_done");
        chk("run_wr_cnt", 64'(wr_cnt), 64'd4);
        chk("run_done_cnt", 64'(done_cnt), 64'd1);
        chk("run_sb_empty", 64'(sb.size()), 64'd0);
        repeat (3) step();

        // reset mid-stage
        clr_stats();
        for (int i = 0; i < 108; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_addr = AW'(i);
            if (i == 0) begin
                start = 1'b1;
                beats = 10'd512;
            end
            if (i[0]) push_pair(i - 1, i);
            step();
            start = 1'b0;
        end
        rst_n = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        chk("mid_uwe", 64'(bus.upper_write_enable), 64'd0);
        chk("mid_lwe", 64'(bus.lower_write_enable), 64'd0);
        chk("mid_ws", 64'(write_select), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_wr_cnt", 64'(wr_cnt), 64'd98);
        sb.delete();
        exp_ws = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("post_rst_no_wr", 64'(wr_cnt), 64'd98);
        run_pair();
        repeat (3) step();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
